// File: rtl/traffic_light_controller_pkg.sv
// Shared encodings, phase durations and output bundle for the intersection controller.
package traffic_light_controller_pkg;

    localparam int unsigned CNT_W = 6;

    localparam logic [1:0] LAMP_G = 2'b00;
    localparam logic [1:0] LAMP_Y = 2'b01;
    localparam logic [1:0] LAMP_R = 2'b10;

    localparam int unsigned T_S1_DEF     = 30;
    localparam int unsigned T_S2_DEF     = 5;
    localparam int unsigned T_S3_DEF     = 35;
    localparam int unsigned T_S4_DEF     = 20;
    localparam int unsigned T_S5_DEF     = 30;
    localparam int unsigned T_S6_DEF     = 5;
    localparam int unsigned T_S7_DEF     = 30;
    localparam int unsigned BUZZ_LEN_DEF = 5;

    typedef enum logic [3:0] {
        S1 = 4'd0,
        S2 = 4'd1,
        S3 = 4'd2,
        S4 = 4'd3,
        S5 = 4'd4,
        S6 = 4'd5,
        S7 = 4'd6,
        EL = 4'd7,
        ER = 4'd8
    } state_t;

    typedef struct packed {
        logic [1:0] t1;
        logic [1:0] t2;
        logic       t1_walk;
        logic       t2_walk;
        logic       buzzer;
    } signals_t;

    // Road 1 green, road 2 red, everything else quiet.
    localparam signals_t SIG_RESET = '{LAMP_G, LAMP_R, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/traffic_light_controller_phase_timer.sv
// Phase dwell counter: counts up each second, clears on phase change or emergency hold.
module traffic_light_controller_phase_timer
    import traffic_light_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt_next_c,
    output logic             tc_c
);

    logic [CNT_W-1:0] cnt;

    // Terminal count marks the last second of the current phase.
    assign tc_c = (cnt == limit - CNT_W'(1));

    // Next count: restart at zero when told, otherwise advance.
    always_comb begin
        cnt_next_c = cnt + CNT_W'(1);
        if (clear) begin
            cnt_next_c = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next_c;
        end
    end

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road signal controller with pedestrian walks, buzzer and emergency pre-emption.
module traffic_light_controller
    import traffic_light_controller_pkg::*;
#(
    parameter int unsigned T_S1     = T_S1_DEF,
    parameter int unsigned T_S2     = T_S2_DEF,
    parameter int unsigned T_S3     = T_S3_DEF,
    parameter int unsigned T_S4     = T_S4_DEF,
    parameter int unsigned T_S5     = T_S5_DEF,
    parameter int unsigned T_S6     = T_S6_DEF,
    parameter int unsigned T_S7     = T_S7_DEF,
    parameter int unsigned BUZZ_LEN = BUZZ_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Emergency_Left,
    input  logic       Emergency_Right,
    output logic [1:0] T1,
    output logic [1:0] T2,
    output logic       T1_WALK,
    output logic       T2_WALK,
    output logic       buzzer
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] cnt_next;
    logic             tc;
    logic             clear;
    signals_t         sig;
    signals_t         sig_next;

    traffic_light_controller_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .limit      (limit),
        .cnt_next_c (cnt_next),
        .tc_c       (tc)
    );

    // Dwell length of the phase currently being timed.
    always_comb begin
        limit = CNT_W'(1);
        case (state)
            S1:      limit = CNT_W'(T_S1);
            S2:      limit = CNT_W'(T_S2);
            S3:      limit = CNT_W'(T_S3);
            S4:      limit = CNT_W'(T_S4);
            S5:      limit = CNT_W'(T_S5);
            S6:      limit = CNT_W'(T_S6);
            S7:      limit = CNT_W'(T_S7);
            default: limit = CNT_W'(1);
        endcase
    end

    // Next phase: emergencies pre-empt immediately (left first), otherwise time out in order.
    always_comb begin
        state_next = state;
        if (Emergency_Left) begin
            state_next = EL;
        end else if (Emergency_Right) begin
            state_next = ER;
        end else begin
            case (state)
                S1:      if (tc) state_next = S2;
                S2:      if (tc) state_next = S3;
                S3:      if (tc) state_next = S4;
                S4:      if (tc) state_next = S5;
                S5:      if (tc) state_next = S6;
                S6:      if (tc) state_next = S7;
                S7:      if (tc) state_next = S1;
                EL:      state_next = S2;
                ER:      state_next = S6;
                default: state_next = S1;
            endcase
        end
        // Counter restarts on any phase change and is pinned at zero during emergencies.
        clear = (state_next != state) || (state_next == EL) || (state_next == ER);
    end

    // Output decode of the upcoming phase/count so the registered lamps line up with the state.
    always_comb begin
        sig_next = SIG_RESET;
        case (state_next)
            S1: begin
                sig_next.t1 = LAMP_G;
                sig_next.t2 = LAMP_R;
            end
            S2: begin
                sig_next.t1 = LAMP_Y;
                sig_next.t2 = LAMP_R;
            end
            S3: begin
                sig_next.t1      = LAMP_R;
                sig_next.t2      = LAMP_R;
                sig_next.t1_walk = 1'b1;
                sig_next.t2_walk = 1'b1;
                sig_next.buzzer  = (cnt_next >= CNT_W'(T_S3 - BUZZ_LEN));
            end
            S4: begin
                sig_next.t1      = LAMP_R;
                sig_next.t2      = LAMP_G;
                sig_next.t1_walk = 1'b1;
                sig_next.buzzer  = (cnt_next < CNT_W'(BUZZ_LEN));
            end
            S5: begin
                sig_next.t1 = LAMP_R;
                sig_next.t2 = LAMP_G;
            end
            S6: begin
                sig_next.t1 = LAMP_R;
                sig_next.t2 = LAMP_Y;
            end
            S7: begin
                sig_next.t1      = LAMP_G;
                sig_next.t2      = LAMP_R;
                sig_next.t2_walk = 1'b1;
            end
            EL: begin
                sig_next.t1     = LAMP_G;
                sig_next.t2     = LAMP_R;
                sig_next.buzzer = 1'b1;
            end
            ER: begin
                sig_next.t1     = LAMP_R;
                sig_next.t2     = LAMP_G;
                sig_next.buzzer = 1'b1;
            end
            default: sig_next = SIG_RESET;
        endcase
    end

    // Phase and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S1;
            sig   <= SIG_RESET;
        end else begin
            state <= state_next;
            sig   <= sig_next;
        end
    end

    assign T1      = sig.t1;
    assign T2      = sig.t2;
    assign T1_WALK = sig.t1_walk;
    assign T2_WALK = sig.t2_walk;
    assign buzzer  = sig.buzzer;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: directed scenarios plus randomized emergencies/resets.
module tb_traffic_light_controller;

    logic       clk;
    logic       reset;
    logic       Emergency_Left;
    logic       Emergency_Right;
    logic [1:0] T1;
    logic [1:0] T2;
    logic       T1_WALK;
    logic       T2_WALK;
    logic       buzzer;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = normal, 1 = left emergency, 2 = right emergency.
    int m_mode = 0;
    int m_ph   = 0;
    int m_el   = 0;

    traffic_light_controller dut (
        .clk             (clk),
        .reset           (reset),
        .Emergency_Left  (Emergency_Left),
        .Emergency_Right (Emergency_Right),
        .T1              (T1),
        .T2              (T2),
        .T1_WALK         (T1_WALK),
        .T2_WALK         (T2_WALK),
        .buzzer          (buzzer)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dur_of(input int p);
        case (p)
            0: return 30;
            1: return 5;
            2: return 35;
            3: return 20;
            4: return 30;
            5: return 5;
            default: return 30;
        endcase
    endfunction

    // Expected {t1, t2, t1_walk, t2_walk, buzzer} for a model situation.
    function automatic logic [6:0] model_out(input int mode, input int ph, input int el);
        logic [1:0] a;
        logic [1:0] b;
        logic       w1;
        logic       w2;
        logic       bz;
        if (mode == 1) return {2'b00, 2'b10, 1'b0, 1'b0, 1'b1};
        if (mode == 2) return {2'b10, 2'b00, 1'b0, 1'b0, 1'b1};
        a = 2'b10; b = 2'b10; w1 = 1'b0; w2 = 1'b0; bz = 1'b0;
        case (ph)
            0: begin a = 2'b00; b = 2'b10; end
            1: begin a = 2'b01; b = 2'b10; end
            2: begin w1 = 1'b1; w2 = 1'b1; bz = (el >= 30); end
            3: begin b = 2'b00; w1 = 1'b1; bz = (el < 5); end
            4: begin b = 2'b00; end
            5: begin b = 2'b01; end
            default: begin a = 2'b00; w2 = 1'b1; end
        endcase
        return {a, b, w1, w2, bz};
    endfunction

    // Model update from the rules: emergencies win, release resumes with a yellow phase.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_ph <= 0; m_el <= 0;
        end else if (Emergency_Left) begin
            m_mode <= 1; m_el <= 0;
        end else if (Emergency_Right) begin
            m_mode <= 2; m_el <= 0;
        end else if (m_mode == 1) begin
            m_mode <= 0; m_ph <= 1; m_el <= 0;
        end else if (m_mode == 2) begin
            m_mode <= 0; m_ph <= 5; m_el <= 0;
        end else if (m_el + 1 == dur_of(m_ph)) begin
            m_el <= 0; m_ph <= (m_ph + 1) % 7;
        end else begin
            m_el <= m_el + 1;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model plus safety invariants.
    always @(negedge clk) begin
        logic [6:0] e;
        e = model_out(m_mode, m_ph, m_el);
        check("model_T1", int'(T1), int'(e[6:5]));
        check("model_T2", int'(T2), int'(e[4:3]));
        check("model_T1_WALK", int'(T1_WALK), int'(e[2]));
        check("model_T2_WALK", int'(T2_WALK), int'(e[1]));
        check("model_buzzer", int'(buzzer), int'(e[0]));
        check("t1_not_11", int'(T1 != 2'b11), 1);
        check("t2_not_11", int'(T2 != 2'b11), 1);
        check("not_both_green", int'(!(T1 == 2'b00 && T2 == 2'b00)), 1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Hand-computed literal expectations.
    task automatic pin(input string name, input int t1, input int t2,
                       input int w1, input int w2, input int bz);
        check({name, "_T1"}, int'(T1), t1);
        check({name, "_T2"}, int'(T2), t2);
        check({name, "_W1"}, int'(T1_WALK), w1);
        check({name, "_W2"}, int'(T2_WALK), w2);
        check({name, "_BZ"}, int'(buzzer), bz);
    endtask

    initial begin
        Emergency_Left  = 1'b0;
        Emergency_Right = 1'b0;
        reset           = 1'b0;
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        #2 reset = 1'b0;

        // Idle normal cycle (lamp codes: G=0, Y=1, R=2).
        pin("c0", 0, 2, 0, 0, 0);
        tick(29);  pin("c29", 0, 2, 0, 0, 0);
        tick(1);   pin("c30", 1, 2, 0, 0, 0);
        tick(5);   pin("c35", 2, 2, 1, 1, 0);
        tick(29);  pin("c64", 2, 2, 1, 1, 0);
        tick(1);   pin("c65", 2, 2, 1, 1, 1);
        tick(5);   pin("c70", 2, 0, 1, 0, 1);
        tick(5);   pin("c75", 2, 0, 1, 0, 0);
        tick(15);  pin("c90", 2, 0, 0, 0, 0);
        tick(30);  pin("c120", 2, 1, 0, 0, 0);
        tick(5);   pin("c125", 0, 2, 0, 1, 0);
        tick(30);  pin("c155", 0, 2, 0, 0, 0);

        // Async reset in the middle of S5.
        tick(100); pin("mid_s5", 2, 0, 0, 0, 0);
        reset = 1'b1;
        #1 pin("async_rst", 0, 2, 0, 0, 0);
        tick(3);
        reset = 1'b0;
        tick(29);  pin("rs_c29", 0, 2, 0, 0, 0);
        tick(1);   pin("rs_c30", 1, 2, 0, 0, 0);

        // Left emergency for 10 cycles during S1.
        tick(125 + 5);
        Emergency_Left = 1'b1;
        tick(1);   pin("el_1", 0, 2, 0, 0, 1);
        tick(9);   pin("el_10", 0, 2, 0, 0, 1);
        Emergency_Left = 1'b0;
        tick(1);   pin("el_rel", 1, 2, 0, 0, 0);
        tick(4);   pin("el_rel4", 1, 2, 0, 0, 0);
        tick(1);   pin("el_s3", 2, 2, 1, 1, 0);

        // Right emergency for 10 cycles during S3.
        tick(3);
        Emergency_Right = 1'b1;
        tick(1);   pin("er_1", 2, 0, 0, 0, 1);
        tick(9);   pin("er_10", 2, 0, 0, 0, 1);
        Emergency_Right = 1'b0;
        tick(1);   pin("er_rel", 2, 1, 0, 0, 0);
        tick(4);   pin("er_rel4", 2, 1, 0, 0, 0);
        tick(1);   pin("er_s7", 0, 2, 0, 1, 0);

        // Enter S6 via a short right pulse, then overlap left and right.
        Emergency_Right = 1'b1; tick(1);
        Emergency_Right = 1'b0; tick(1);
        pin("s6", 2, 1, 0, 0, 0);
        Emergency_Right = 1'b1; tick(1); pin("ov_er", 2, 0, 0, 0, 1);
        Emergency_Left  = 1'b1; tick(1); pin("ov_el", 0, 2, 0, 0, 1);
        Emergency_Left  = 1'b0; tick(1); pin("ov_er2", 2, 0, 0, 0, 1);
        Emergency_Right = 1'b0; tick(1); pin("ov_rel", 2, 1, 0, 0, 0);

        // Both raised on the same edge: left wins.
        Emergency_Left = 1'b1; Emergency_Right = 1'b1;
        tick(1); pin("both", 0, 2, 0, 0, 1);
        Emergency_Left = 1'b0; Emergency_Right = 1'b0;
        tick(1); pin("both_rel", 1, 2, 0, 0, 0);

        // Randomized emergencies and occasional async resets, checked by the model.
        for (int i = 0; i < 6000; i++) begin
            if (Emergency_Left) begin
                if ($urandom_range(0, 7) == 0) Emergency_Left = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                Emergency_Left = 1'b1;
            end
            if (Emergency_Right) begin
                if ($urandom_range(0, 7) == 0) Emergency_Right = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                Emergency_Right = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1;
                tick($urandom_range(1, 3));
                reset = 1'b0;
            end
            tick(1);
        end
        Emergency_Left  = 1'b0;
        Emergency_Right = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
